// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
//
// Purpose : bundles the start/busy/done handshake together with the operand
//           and result buses of serial_subtractor.
//
// Parameter:
//   WIDTH  operand/result width; must match the WIDTH of the attached
//          serial_subtractor.
//
// Signals (direction given from the subtractor's point of view):
//   start  in   request pulse, accepted only when the subtractor is not busy
//   a      in   minuend, latched on the accepted start edge
//   b      in   subtrahend, latched on the accepted start edge
//   bin    in   borrow-in, latched on the accepted start edge
//   busy   out  high while an operation is running
//   done   out  one-cycle pulse, diff/bout (and ovf) valid
//   diff   out  registered difference, held until the next completion
//   bout   out  registered borrow-out
//   ovf    out  signed overflow flag (only when SERIAL_SUB_OVF_EN is defined)
//
// Modports:
//   master  requester side (drives start/a/b/bin)
//   slave   subtractor side (drives busy/done/diff/bout/ovf)
//
// Configuration macro: SERIAL_SUB_OVF_EN adds the ovf signal.
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);

    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif

endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
//
// Purpose : bit-serial subtractor computing {bout, diff} = a - b - bin,
//           one bit per clock, LSB first, using a single full-subtractor
//           cell and a registered borrow.
//
// Parameters:
//   WIDTH  operand and result width in bits (1..32)
//   CNT_W  bit-counter width, derived from WIDTH; do not override
//
// Ports:
//   clk    system clock, all state updates on the rising edge
//   reset  synchronous active-high reset
//   bus    serial_subtractor_if.slave
//            start/a/b/bin in, busy/done/diff/bout(/ovf) out
//
// Timing: a start accepted at edge E0 keeps busy high for WIDTH cycles; done
// pulses for one cycle after edge E(WIDTH). A start during the done cycle is
// accepted back-to-back; a start while busy is ignored.
//
// Configuration macro: SERIAL_SUB_OVF_EN adds the signed overflow flag ovf.
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be in 1..32");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             br_q, br_d;
    logic             bout_q, bout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef SERIAL_SUB_OVF_EN
    // Sign bits are kept separately because sa/sb are shifted away.
    logic sign_a_q, sign_a_d;
    logic sign_b_q, sign_b_d;
    logic ovf_q, ovf_d;
`endif

    // ------------------------------------------------------------------
    // Full-subtractor cell working on the current LSBs
    // ------------------------------------------------------------------
    logic             d_bit;
    logic             br_next;
    logic [WIDTH-1:0] res_shift;
    logic             last_bit;
    logic             accept;

    assign d_bit   = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_next = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);

    // Result shifts right, new bit enters at the MSB. Written this way so
    // that WIDTH=1 needs no special slice.
    always_comb begin
        res_shift            = res_q >> 1;
        res_shift[WIDTH-1]   = d_bit;
    end

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Start is honoured in IDLE and, for back-to-back use, in DONE.
    assign accept = bus.start && (state_q != RUN);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        ovf_d    = ovf_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    sa_d    = bus.a;
                    sb_d    = bus.b;
                    br_d    = bus.bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_SUB_OVF_EN
                    sign_a_d = bus.a[WIDTH-1];
                    sign_b_d = bus.b[WIDTH-1];
`endif
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                sa_d  = sa_q >> 1;
                sb_d  = sb_q >> 1;
                br_d  = br_next;
                res_d = res_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    diff_d  = res_shift;
                    bout_d  = br_next;
                    state_d = DONE;
`ifdef SERIAL_SUB_OVF_EN
                    // Overflow: operand signs differ and the result sign
                    // differs from the minuend sign.
                    ovf_d = (sign_a_q != sign_b_q) && (res_shift[WIDTH-1] != sign_a_q);
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers, synchronous reset
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from flops only
    // ------------------------------------------------------------------
    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule
